// File: rtl/pe_ws_db.sv
// Weight-stationary MAC processing element with double-buffered (shadow/active) weights.
// Optional build macro PE_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module pe_ws_db #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int SIGNED  = 1,
    parameter int ROW_IDX = 0,
    parameter int TAG_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_valid_in,
    input  logic              swap_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_valid_out,
    output logic              swap_out,
    input  logic [DATA_W-1:0] w_in,
    input  logic [TAG_W-1:0]  w_tag_in,
    input  logic              w_valid_in,
    output logic [DATA_W-1:0] w_out,
    output logic [TAG_W-1:0]  w_tag_out,
    output logic              w_valid_out,
    input  logic [ACC_W-1:0]  psum_in,
    output logic [ACC_W-1:0]  psum_out,
    output logic              psum_valid_out,
    output logic              ovf
);

    localparam int PROD_W = 2 * DATA_W;

    if (ACC_W < PROD_W) begin : g_acc_chk
        $error("pe_ws_db: ACC_W must be >= 2*DATA_W");
    end
    if ((64'd1 << TAG_W) <= 64'(ROW_IDX)) begin : g_tag_chk
        $error("pe_ws_db: TAG_W too narrow to address ROW_IDX");
    end

    logic [DATA_W-1:0] shadow_w;
    logic [DATA_W-1:0] active_w;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W:0]    sum;
    logic              ovf_det;
    logic [ACC_W-1:0]  result;
    logic              capture;

    assign capture = w_valid_in && (w_tag_in == TAG_W'(ROW_IDX));

    // Operands are widened to the full product width first so the product is exact either way.
    always_comb begin
        prod     = '0;
        prod_ext = '0;
        if (SIGNED != 0) begin
            prod     = $signed({{DATA_W{a_in[DATA_W-1]}}, a_in}) *
                       $signed({{DATA_W{active_w[DATA_W-1]}}, active_w});
            prod_ext = ACC_W'($signed(prod));
        end else begin
            prod     = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, active_w};
            prod_ext = ACC_W'(prod);
        end
    end

    always_comb begin
        sum     = {1'b0, psum_in} + {1'b0, prod_ext};
        ovf_det = 1'b0;
        if (SIGNED != 0) begin
            ovf_det = (psum_in[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum[ACC_W-1] != psum_in[ACC_W-1]);
        end else begin
            ovf_det = sum[ACC_W];
        end
    end

`ifdef PE_SATURATE_EN
    // Signed overflow direction follows the (shared) operand sign.
    always_comb begin
        result = sum[ACC_W-1:0];
        if (ovf_det) begin
            if (SIGNED != 0) begin
                result = psum_in[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                          : {1'b0, {(ACC_W-1){1'b1}}};
            end else begin
                result = '1;
            end
        end
    end
`else
    assign result = sum[ACC_W-1:0];
`endif

    // The swap reads the pre-edge shadow, so a same-cycle capture lands only in shadow_w.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_w       <= '0;
            active_w       <= '0;
            a_out          <= '0;
            a_valid_out    <= 1'b0;
            swap_out       <= 1'b0;
            w_out          <= '0;
            w_tag_out      <= '0;
            w_valid_out    <= 1'b0;
            psum_out       <= '0;
            psum_valid_out <= 1'b0;
            ovf            <= 1'b0;
        end else begin
            w_out       <= w_in;
            w_tag_out   <= w_tag_in;
            w_valid_out <= w_valid_in;
            if (capture) begin
                shadow_w <= w_in;
            end
            if (swap_in) begin
                active_w <= shadow_w;
            end
            if (clear) begin
                a_out          <= '0;
                a_valid_out    <= 1'b0;
                swap_out       <= 1'b0;
                psum_out       <= '0;
                psum_valid_out <= 1'b0;
                ovf            <= 1'b0;
            end else begin
                a_out       <= a_in;
                a_valid_out <= a_valid_in;
                swap_out    <= swap_in;
                if (a_valid_in) begin
                    psum_out       <= result;
                    psum_valid_out <= 1'b1;
                    if (ovf_det) begin
                        ovf <= 1'b1;
                    end
                end else begin
                    psum_valid_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pe_ws_db.sv
// Directed-vector bench for pe_ws_db: a signed and an unsigned 16-bit-accumulator PE at row 2.
// Expectations for overflow cases follow PE_SATURATE_EN when it is defined.
module tb_pe_ws_db;

    logic       clk = 1'b0;
    logic       rst, clear;
    logic [7:0] a_in, w_in;
    logic       a_valid_in, swap_in, w_valid_in;
    logic [3:0] w_tag_in;
    logic [15:0] psum_in;

    logic [7:0]  s_a_out, s_w_out, u_a_out, u_w_out;
    logic        s_a_valid_out, s_swap_out, s_w_valid_out, s_psum_valid_out, s_ovf;
    logic        u_a_valid_out, u_swap_out, u_w_valid_out, u_psum_valid_out, u_ovf;
    logic [3:0]  s_w_tag_out, u_w_tag_out;
    logic [15:0] s_psum_out, u_psum_out;

    int nvec = 0;
    int nerr = 0;

`ifdef PE_SATURATE_EN
    localparam logic [15:0] POS_OVF = 16'h7FFF;
    localparam logic [15:0] NEG_OVF = 16'h8000;
    localparam logic [15:0] U_OVF   = 16'hFFFF;
`else
    localparam logic [15:0] POS_OVF = 16'h8020;
    localparam logic [15:0] NEG_OVF = 16'h7FF6;
    localparam logic [15:0] U_OVF   = 16'h00DB;
`endif

    pe_ws_db #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .ROW_IDX(2), .TAG_W(4)) dut_s (
        .clk(clk), .rst(rst), .clear(clear),
        .a_in(a_in), .a_valid_in(a_valid_in), .swap_in(swap_in),
        .a_out(s_a_out), .a_valid_out(s_a_valid_out), .swap_out(s_swap_out),
        .w_in(w_in), .w_tag_in(w_tag_in), .w_valid_in(w_valid_in),
        .w_out(s_w_out), .w_tag_out(s_w_tag_out), .w_valid_out(s_w_valid_out),
        .psum_in(psum_in), .psum_out(s_psum_out), .psum_valid_out(s_psum_valid_out),
        .ovf(s_ovf)
    );

    pe_ws_db #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .ROW_IDX(2), .TAG_W(4)) dut_u (
        .clk(clk), .rst(rst), .clear(clear),
        .a_in(a_in), .a_valid_in(a_valid_in), .swap_in(swap_in),
        .a_out(u_a_out), .a_valid_out(u_a_valid_out), .swap_out(u_swap_out),
        .w_in(w_in), .w_tag_in(w_tag_in), .w_valid_in(w_valid_in),
        .w_out(u_w_out), .w_tag_out(u_w_tag_out), .w_valid_out(u_w_valid_out),
        .psum_in(psum_in), .psum_out(u_psum_out), .psum_valid_out(u_psum_valid_out),
        .ovf(u_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        clr;
        logic [7:0]  a;
        logic        av;
        logic        sw;
        logic [7:0]  w;
        logic [3:0]  tag;
        logic        wv;
        logic [15:0] psum;
        logic [40:0] exp;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic applyStimulus(input vec_t v);
        rst        = v.rst;
        clear      = v.clr;
        a_in       = v.a;
        a_valid_in = v.av;
        swap_in    = v.sw;
        w_in       = v.w;
        w_tag_in   = v.tag;
        w_valid_in = v.wv;
        psum_in    = v.psum;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [40:0] got, input logic [40:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("[TB] FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic logic [40:0] sOut();
        return {s_psum_out, s_psum_valid_out, s_ovf, s_a_out, s_a_valid_out, s_swap_out,
                s_w_out, s_w_tag_out, s_w_valid_out};
    endfunction

    function automatic logic [40:0] uOut();
        return {23'd0, u_psum_out, u_psum_valid_out, u_ovf};
    endfunction

    initial begin
        // Fields: rst clr a av sw w tag wv psum | psum pv ovf a_out av_out sw_out w_out tag_out wv_out
        vecs[0]  = {1'b1,1'b0,8'h55,1'b1,1'b1,8'h33,4'd2,1'b1,16'h0064, {16'h0000,1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,4'd0,1'b0}};
        vecs[1]  = {1'b0,1'b0,8'h00,1'b0,1'b0,8'h05,4'd1,1'b1,16'h0000, {16'h0000,1'b0,1'b0,8'h00,1'b0,1'b0,8'h05,4'd1,1'b1}};
        vecs[2]  = {1'b0,1'b0,8'h00,1'b0,1'b0,8'h07,4'd2,1'b1,16'h0000, {16'h0000,1'b0,1'b0,8'h00,1'b0,1'b0,8'h07,4'd2,1'b1}};
        vecs[3]  = {1'b0,1'b0,8'h00,1'b0,1'b1,8'h09,4'd3,1'b1,16'h0000, {16'h0000,1'b0,1'b0,8'h00,1'b0,1'b1,8'h09,4'd3,1'b1}};
        vecs[4]  = {1'b0,1'b0,8'h03,1'b1,1'b0,8'h00,4'd0,1'b0,16'h000A, {16'h001F,1'b1,1'b0,8'h03,1'b1,1'b0,8'h00,4'd0,1'b0}};
        vecs[5]  = {1'b0,1'b0,8'h02,1'b1,1'b1,8'h04,4'd2,1'b1,16'h0000, {16'h000E,1'b1,1'b0,8'h02,1'b1,1'b1,8'h04,4'd2,1'b1}};
        vecs[6]  = {1'b0,1'b0,8'h01,1'b1,1'b1,8'h00,4'd0,1'b0,16'h0000, {16'h0007,1'b1,1'b0,8'h01,1'b1,1'b1,8'h00,4'd0,1'b0}};
        vecs[7]  = {1'b0,1'b0,8'h01,1'b1,1'b0,8'h00,4'd0,1'b0,16'h0000, {16'h0004,1'b1,1'b0,8'h01,1'b1,1'b0,8'h00,4'd0,1'b0}};
        vecs[8]  = {1'b0,1'b0,8'h00,1'b0,1'b0,8'hFD,4'd2,1'b1,16'h0000, {16'h0004,1'b0,1'b0,8'h00,1'b0,1'b0,8'hFD,4'd2,1'b1}};
        vecs[9]  = {1'b0,1'b0,8'h00,1'b0,1'b1,8'h00,4'd0,1'b0,16'h0000, {16'h0004,1'b0,1'b0,8'h00,1'b0,1'b1,8'h00,4'd0,1'b0}};
        vecs[10] = {1'b0,1'b0,8'h80,1'b1,1'b0,8'h00,4'd0,1'b0,16'hFFFB, {16'h017B,1'b1,1'b0,8'h80,1'b1,1'b0,8'h00,4'd0,1'b0}};
        vecs[11] = {1'b0,1'b0,8'h11,1'b0,1'b0,8'h00,4'd0,1'b0,16'h0000, {16'h017B,1'b0,1'b0,8'h11,1'b0,1'b0,8'h00,4'd0,1'b0}};
        vecs[12] = {1'b0,1'b1,8'h02,1'b1,1'b0,8'h21,4'd5,1'b1,16'h0000, {16'h0000,1'b0,1'b0,8'h00,1'b0,1'b0,8'h21,4'd5,1'b1}};
        vecs[13] = {1'b0,1'b0,8'h02,1'b1,1'b0,8'h00,4'd0,1'b0,16'h0000, {16'hFFFA,1'b1,1'b0,8'h02,1'b1,1'b0,8'h00,4'd0,1'b0}};
        vecs[14] = {1'b0,1'b0,8'h00,1'b0,1'b0,8'h0A,4'd2,1'b1,16'h0000, {16'hFFFA,1'b0,1'b0,8'h00,1'b0,1'b0,8'h0A,4'd2,1'b1}};
        vecs[15] = {1'b0,1'b0,8'h00,1'b0,1'b1,8'h00,4'd0,1'b0,16'h0000, {16'hFFFA,1'b0,1'b0,8'h00,1'b0,1'b1,8'h00,4'd0,1'b0}};
        vecs[16] = {1'b0,1'b0,8'h0A,1'b1,1'b0,8'h00,4'd0,1'b0,16'h7FBC, {POS_OVF,1'b1,1'b1,8'h0A,1'b1,1'b0,8'h00,4'd0,1'b0}};
        vecs[17] = {1'b0,1'b0,8'h01,1'b1,1'b0,8'h00,4'd0,1'b0,16'h0005, {16'h000F,1'b1,1'b1,8'h01,1'b1,1'b0,8'h00,4'd0,1'b0}};
        vecs[18] = {1'b0,1'b0,8'hFF,1'b1,1'b0,8'h00,4'd0,1'b0,16'h8000, {NEG_OVF,1'b1,1'b1,8'hFF,1'b1,1'b0,8'h00,4'd0,1'b0}};
        vecs[19] = {1'b0,1'b1,8'h07,1'b1,1'b1,8'h00,4'd0,1'b0,16'h0000, {16'h0000,1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,4'd0,1'b0}};
        vecs[20] = {1'b1,1'b0,8'h44,1'b1,1'b1,8'h66,4'd2,1'b1,16'h1234, {16'h0000,1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,4'd0,1'b0}};
        vecs[21] = {1'b0,1'b0,8'h00,1'b0,1'b1,8'h00,4'd0,1'b0,16'h0000, {16'h0000,1'b0,1'b0,8'h00,1'b0,1'b1,8'h00,4'd0,1'b0}};
        vecs[22] = {1'b0,1'b0,8'h05,1'b1,1'b0,8'h00,4'd0,1'b0,16'h0003, {16'h0003,1'b1,1'b0,8'h05,1'b1,1'b0,8'h00,4'd0,1'b0}};

        rst = 1'b1; clear = 1'b0; a_in = '0; a_valid_in = 1'b0; swap_in = 1'b0;
        w_in = '0; w_tag_in = '0; w_valid_in = 1'b0; psum_in = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i), sOut(), vecs[i].exp);
        end

        // Unsigned PE: exact fit at the top of the range, then a carry-out.
        applyStimulus({1'b0,1'b0,8'h00,1'b0,1'b0,8'h01,4'd2,1'b1,16'h0000, 41'd0});
        applyStimulus({1'b0,1'b0,8'h00,1'b0,1'b1,8'h00,4'd0,1'b0,16'h0000, 41'd0});
        applyStimulus({1'b0,1'b0,8'h23,1'b1,1'b0,8'h00,4'd0,1'b0,16'hFFDC, 41'd0});
        checkOutput("u_fit", uOut(), {23'd0, 16'hFFFF, 1'b1, 1'b0});
        applyStimulus({1'b0,1'b0,8'hFF,1'b1,1'b0,8'h00,4'd0,1'b0,16'hFFDC, 41'd0});
        checkOutput("u_ovf", uOut(), {23'd0, U_OVF, 1'b1, 1'b1});
        applyStimulus({1'b0,1'b0,8'h01,1'b1,1'b0,8'h00,4'd0,1'b0,16'h0010, 41'd0});
        checkOutput("u_sticky", uOut(), {23'd0, 16'h0011, 1'b1, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/pe_ws_db.md
Name: pe_ws_db

Overview:
- Next-generation weight-stationary MAC processing element for the systolic array.
- Fully parametrised data and accumulator widths, signed or unsigned arithmetic.
- Double-buffered (shadow/active) weights, loaded over a tagged vertical weight chain, so the next weight tile loads while the current tile computes.
- Valid-qualified activation and partial-sum flow, plus a sticky overflow flag; one instance per array cell.

Parameters:
- DATA_W, 8, activation/weight width.
- ACC_W, 24, partial-sum width; must be >= 2*DATA_W (elaboration error otherwise).
- SIGNED, 1, 1 = two's-complement operands and accumulation; 0 = unsigned.
- ROW_IDX, 0, this PE's row index; matched against the weight tag.
- TAG_W, 4, weight tag width; must satisfy 2^TAG_W > ROW_IDX.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- clear  in  1  synchronous datapath clear; weights are unaffected.
- a_in  in  DATA_W  activation from the west.
- a_valid_in  in  1  a_in qualifier.
- swap_in  in  1  shadow->active swap token, travels with activations.
- a_out  out  DATA_W  activation to the east (registered).
- a_valid_out  out  1  registered a_valid_in.
- swap_out  out  1  registered swap_in.
- w_in  in  DATA_W  weight chain data from the north.
- w_tag_in  in  TAG_W  destination row of w_in.
- w_valid_in  in  1  w_in qualifier.
- w_out  out  DATA_W  weight chain data to the south (registered).
- w_tag_out  out  TAG_W  registered w_tag_in.
- w_valid_out  out  1  registered w_valid_in.
- psum_in  in  ACC_W  partial sum from the north.
- psum_out  out  ACC_W  partial sum to the south (registered).
- psum_valid_out  out  1  psum_out qualifier.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (rst=1 at posedge) clears every register to 0: shadow_w, active_w, a_out, a_valid_out, swap_out, w_out, w_tag_out, w_valid_out, psum_out, psum_valid_out, ovf. rst has priority over clear and all other inputs. Reset mid-operation discards in-flight data, including weights.
- clear=1 (and rst=0) zeroes a_out, a_valid_out, swap_out, psum_out, psum_valid_out and ovf. It does not affect shadow_w, active_w or the w_* chain registers.
- Weight chain: every cycle w_out<=w_in, w_tag_out<=w_tag_in, w_valid_out<=w_valid_in. The chain always forwards, including the word consumed here. Latency is 1 cycle per PE.
- Shadow capture: if w_valid_in && w_tag_in==ROW_IDX, then shadow_w<=w_in. Otherwise shadow_w holds.
- Swap: if swap_in=1, then active_w<=shadow_w at that edge. The MAC in the same cycle still uses the old active_w.
  - If a capture and a swap occur in the same cycle, active_w takes the old shadow_w and shadow_w takes w_in.
  - swap_out<=swap_in in every cycle.
- Activation path: a_out<=a_in and a_valid_out<=a_valid_in every cycle, whether or not a_valid_in is set. Latency is 1 cycle.
- MAC:
  - prod = a_in*active_w, 2*DATA_W bits, signed or unsigned per SIGNED.
  - prod is sign- or zero-extended to ACC_W. sum = psum_in + ext(prod), computed in ACC_W+1 bits.
  - If a_valid_in=1: psum_out<=result (see Optional Feature) and psum_valid_out<=1.
  - If a_valid_in=0: psum_out holds and psum_valid_out<=0.
  - Latency from a_in/psum_in to psum_out is 1 cycle.
- Overflow detection:
  - SIGNED=1: both operands have the same sign and the sum sign differs.
  - SIGNED=0: carry out of bit ACC_W-1.
  - Only evaluated when a_valid_in=1.
- ovf sets on a detected overflow and stays set until rst or clear.

Optional Feature:
- Macro: PE_SATURATE_EN.
- Defined: on overflow, result clamps. SIGNED=1 clamps to 2^(ACC_W-1)-1 on positive overflow and -2^(ACC_W-1) on negative overflow. SIGNED=0 clamps to 2^ACC_W-1. ovf behaves as above.
- Undefined: result = sum modulo 2^ACC_W (wrap). ovf is still computed and set identically; saturation logic is absent.

Test Plan:
- Reset/clear: drive rst=1 with nonzero inputs -> all outputs 0 next cycle. Load weights, then pulse clear -> psum_out=0, ovf=0, active_w kept (next MAC with a=2 uses the old weight).
- Tagged load and swap (ROW_IDX=2): chain words (w=5,tag=1), (w=7,tag=2), (w=9,tag=3) -> w_* out each 1 cycle later; shadow_w=7. swap_in=1, then a_in=3, psum_in=10, valid -> psum_out=31.
- Overlap: active_w=7 computing; same cycle capture w=4 and swap -> that cycle's MAC uses 7; next swap makes active_w=4. Verifies the old shadow value was promoted first.
- Signed MAC (SIGNED=1, DATA_W=8): active_w=-3 (0xFD), a_in=-128, psum_in=-5 -> psum_out=379. With a_valid_in=0 -> psum_out holds and psum_valid_out=0.
- Overflow (SIGNED=1, ACC_W=16): psum_in=32700, a_in=10, w=10 -> ovf=1; psum_out=32767 with PE_SATURATE_EN, -32736 without. A subsequent non-overflowing MAC leaves ovf=1.
- Unsigned (SIGNED=0, ACC_W=16): psum_in=65500, a=255, w=1 -> ovf=1; psum_out=65535 with PE_SATURATE_EN, 219 without.
